// File: rtl/pe_dot_row_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_dot_row_pkg
//  Purpose  : Shared types and constants for the pe_dot_row datapath:
//             lane geometry, product/result widths and the control FSM
//             state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package pe_dot_row_pkg;

    localparam int LANES  = 8;          // lanes per pe_data word
    localparam int DW     = 16;         // lane / weight width
    localparam int PROD_W = 2 * DW;     // full-precision lane product
    localparam int RES_W  = 35;         // sum of 8 products, cannot overflow

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage : pe_dot_row_pkg
`default_nettype wire

// File: rtl/pe_dot_row_if.sv
`default_nettype none
// ============================================================================
//  Module   : pe_dot_row_if
//  Purpose  : Bus bundle between the upstream feeders and pe_dot_row.
//             master : drives rd_sop, pe_data, wt_vld, wt_data
//             slave  : drives res_vld/sop/eop, res_data, busy, err
//  Revision : 1.0  initial release
// ============================================================================
interface pe_dot_row_if;
    import pe_dot_row_pkg::*;

    logic                    rd_sop;
    logic [LANES*DW-1:0]     pe_data;
    logic                    wt_vld;
    logic [DW-1:0]           wt_data;
    logic                    res_vld;
    logic                    res_sop;
    logic                    res_eop;
    logic [RES_W-1:0]        res_data;
    logic                    busy;
    logic                    err;

    modport master (
        output rd_sop, pe_data, wt_vld, wt_data,
        input  res_vld, res_sop, res_eop, res_data, busy, err
    );

    modport slave (
        input  rd_sop, pe_data, wt_vld, wt_data,
        output res_vld, res_sop, res_eop, res_data, busy, err
    );

endinterface : pe_dot_row_if
`default_nettype wire

// File: rtl/pe_add_tree8.sv
`default_nettype none
// ============================================================================
//  Module   : pe_add_tree8
//  Purpose  : Sums eight signed 32-bit products into a 35-bit result with a
//             single output register. The sum holds when i_vld is low.
//  Ports    : clk, rst          clock / synchronous active-high reset
//             i_vld, i_prod     product vector and its valid
//             o_vld, o_sum      registered sum and its valid
//  Revision : 1.0  initial release
// ============================================================================
module pe_add_tree8
    import pe_dot_row_pkg::*;
(
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_vld,
    input  wire logic [LANES-1:0][PROD_W-1:0]  i_prod,
    output      logic                          o_vld,
    output      logic [RES_W-1:0]              o_sum
);

    logic signed [RES_W-1:0] w_ext [LANES];
    logic signed [RES_W-1:0] w_l1  [LANES/2];
    logic signed [RES_W-1:0] w_l2  [LANES/4];
    logic signed [RES_W-1:0] w_sum;

    // Sign-extend every product to the full result width before adding.
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_ext
            assign w_ext[g] = {{(RES_W-PROD_W){i_prod[g][PROD_W-1]}}, i_prod[g]};
        end
        for (genvar g = 0; g < LANES/2; g++) begin : g_l1
            assign w_l1[g] = w_ext[2*g] + w_ext[2*g+1];
        end
        for (genvar g = 0; g < LANES/4; g++) begin : g_l2
            assign w_l2[g] = w_l1[2*g] + w_l1[2*g+1];
        end
    endgenerate

    assign w_sum = w_l2[0] + w_l2[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_sum <= '0;
        end else begin
            o_vld <= i_vld;
            if (i_vld) begin
                o_sum <= w_sum;
            end
        end
    end

endmodule : pe_add_tree8
`default_nettype wire

// File: rtl/pe_dot_row.sv
`default_nettype none
// ============================================================================
//  Module   : pe_dot_row
//  Purpose  : Row processing element. Per window it samples WIN_LEN pe_data
//             words, starting RD_LAT cycles after rd_sop, and emits the dot
//             product of each word with an 8-entry active weight bank.
//             Weights stream into a shadow bank and are promoted to the
//             active bank when a window is accepted.
//  Ports    : clk, rst   clock / synchronous active-high reset
//             bus        pe_dot_row_if.slave (rd_sop, pe_data, wt_vld,
//                        wt_data, res_vld/sop/eop, res_data, busy, err)
//  Revision : 1.0  initial release
// ============================================================================
module pe_dot_row
    import pe_dot_row_pkg::*;
#(
    parameter int RD_LAT  = 2,     // 1..15
    parameter int WIN_LEN = 8      // 1..16
) (
    input wire logic      clk,
    input wire logic      rst,
    pe_dot_row_if.slave   bus
);

    localparam logic [3:0] c_wait_load = 4'(RD_LAT - 1);
    localparam logic [3:0] c_run_load  = 4'(WIN_LEN - 1);

    state_t                     r_state, w_state_nxt;
    logic [3:0]                 r_cnt, w_cnt_nxt;
    logic                       w_accept;
    logic                       w_sample, w_first, w_last;

    logic signed [DW-1:0]       r_shadow [LANES];
    logic signed [DW-1:0]       r_active [LANES];
    logic [2:0]                 r_wptr;
    logic [2:0]                 w_wr_idx;

    logic [LANES-1:0][PROD_W-1:0] r_prod;
    logic                       r_p_vld, r_p_sop, r_p_eop;
    logic                       r_s_sop, r_s_eop;
    logic                       w_t_vld;
    logic [RES_W-1:0]           w_t_sum;
    logic                       r_err;

    assign w_accept = (r_state == ST_IDLE) && bus.rd_sop;

    // ------------------------------------------------------------------
    // Control FSM. The WAIT counter is loaded with RD_LAT-1 on entry and
    // RUN is entered on the edge where it reaches zero, so the first sample
    // lands exactly RD_LAT cycles after rd_sop. With RD_LAT=1 there is no
    // room for a WAIT cycle and IDLE hands over straight to RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sample    = 1'b0;
        w_first     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rd_sop) begin
                    if (RD_LAT == 1) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = c_run_load;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_wait_load;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = c_run_load;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RUN: begin
                w_sample = 1'b1;
                w_first  = (r_cnt == c_run_load);
                w_last   = (r_cnt == 4'd0);
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = 4'd1;     // two DRAIN cycles
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Weight banks. The active copy reads the old shadow contents, so a
    // weight written in the accept cycle lands in shadow[0] for the next
    // window rather than leaking into the one being started.
    // ------------------------------------------------------------------
    assign w_wr_idx = w_accept ? 3'd0 : r_wptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_wptr <= '0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (bus.wt_vld) begin
                r_shadow[w_wr_idx] <= bus.wt_data;
                r_wptr             <= w_wr_idx + 3'd1;
            end else if (w_accept) begin
                r_wptr <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Product stage: one registered signed 16x16 product per lane, with
    // the window-position tags travelling alongside.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod  <= '0;
            r_p_vld <= 1'b0;
            r_p_sop <= 1'b0;
            r_p_eop <= 1'b0;
        end else begin
            r_p_vld <= w_sample;
            r_p_sop <= w_sample & w_first;
            r_p_eop <= w_sample & w_last;
            if (w_sample) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= $signed(bus.pe_data[DW*i +: DW]) * r_active[i];
                end
            end
        end
    end

    pe_add_tree8 u_add_tree (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (r_p_vld),
        .i_prod (r_prod),
        .o_vld  (w_t_vld),
        .o_sum  (w_t_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_sop <= 1'b0;
            r_s_eop <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_s_sop <= r_p_vld & r_p_sop;
            r_s_eop <= r_p_vld & r_p_eop;
            // A start pulse outside IDLE is dropped and latched as an error.
            if (bus.rd_sop && (r_state != ST_IDLE)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.res_vld  = w_t_vld;
    assign bus.res_sop  = r_s_sop;
    assign bus.res_eop  = r_s_eop;
    assign bus.res_data = w_t_sum;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.err      = r_err;

endmodule : pe_dot_row
`default_nettype wire

// File: tb/tb_pe_dot_row.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_dot_row
//  Purpose  : Self-checking bench for pe_dot_row. dut0 (RD_LAT=2, WIN_LEN=8)
//             is tracked cycle by cycle by a window-level reference model;
//             dut1 (WIN_LEN=1) covers back-to-back single-word windows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pe_dot_row;

    localparam int RD_LAT  = 2;
    localparam int WIN_LEN = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pe_dot_row_if bus0 ();
    pe_dot_row_if bus1 ();

    pe_dot_row #(.RD_LAT(RD_LAT), .WIN_LEN(WIN_LEN)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pe_dot_row #(.RD_LAT(2), .WIN_LEN(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model for dut0: tracks window start cycles and computes
    // each dot product directly; results wait in a queue until due.
    // ------------------------------------------------------------------
    typedef struct {
        int     due;
        longint val;
        bit     sop;
        bit     eop;
    } res_t;

    int          m_shadow [8];
    int          m_active [8];
    int          m_wptr   = 0;
    int          m_cyc    = 0;
    int          m_start  = 0;
    bit          m_win    = 0;
    logic        m_vld    = 0;
    logic        m_sop    = 0;
    logic        m_eop    = 0;
    logic        m_busy   = 0;
    logic        m_err    = 0;
    logic [34:0] m_data   = '0;
    res_t        m_q [$];

    function automatic longint dot(input logic [127:0] d, input int w [8]);
        longint s = 0;
        for (int i = 0; i < 8; i++) begin
            s += longint'($signed(d[16*i +: 16])) * longint'(w[i]);
        end
        return s;
    endfunction

    task automatic model_step();
        int   k;
        res_t e;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_wptr = 0;
            m_win  = 0;
            m_err  = 0;
            m_data = '0;
            m_q.delete();
        end else begin
            if (m_win) begin
                k = m_cyc - m_start - RD_LAT;
                if (k >= 0 && k < WIN_LEN) begin
                    e.due = m_cyc + 2;
                    e.val = dot(bus0.pe_data, m_active);
                    e.sop = (k == 0);
                    e.eop = (k == WIN_LEN - 1);
                    m_q.push_back(e);
                end
            end
            if (bus0.rd_sop) begin
                if (m_busy) begin
                    m_err = 1;
                end else begin
                    m_win    = 1;
                    m_start  = m_cyc;
                    m_active = m_shadow;
                    m_wptr   = 0;
                end
            end
            if (bus0.wt_vld) begin
                m_shadow[m_wptr] = int'($signed(bus0.wt_data));
                m_wptr = (m_wptr + 1) % 8;
            end
        end
        m_cyc++;
        m_busy = m_win && (m_cyc > m_start) && (m_cyc <= m_start + RD_LAT + WIN_LEN + 1);
        m_vld  = 0;
        m_sop  = 0;
        m_eop  = 0;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            e      = m_q.pop_front();
            m_vld  = 1;
            m_sop  = e.sop;
            m_eop  = e.eop;
            m_data = 35'(e.val);
        end
    endtask

    // Advance one clock; inputs are stable while the model and DUT sample.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_weights0(input logic [15:0] base, input bit rnd);
        for (int i = 0; i < 8; i++) begin
            bus0.wt_vld  = 1'b1;
            bus0.wt_data = rnd ? 16'($urandom) : base + 16'(i);
            tick();
        end
        bus0.wt_vld = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus0.res_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", bus0.res_vld); end
        checks++; if (bus0.res_sop !== 1'b0) begin errors++; $display("FAIL reset_sop got %b want 0", bus0.res_sop); end
        checks++; if (bus0.res_eop !== 1'b0) begin errors++; $display("FAIL reset_eop got %b want 0", bus0.res_eop); end
        checks++; if (bus0.res_data !== 35'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus0.res_data); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
        checks++; if (bus0.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus0.err); end
        checks++; if ({bus1.res_vld, bus1.busy, bus1.err} !== 3'b000) begin errors++; $display("FAIL reset_dut1 got %b want 000", {bus1.res_vld, bus1.busy, bus1.err}); end
        rst = 1'b0;
        tick();
    endtask

    // Weights 1..8, all lanes 1 -> eight results of 36, first 4 cycles on.
    task automatic test_basic();
        int n_res = 0;
        int first = -1;
        load_weights0(16'd1, 1'b0);
        bus0.pe_data = {8{16'd1}};
        bus0.rd_sop  = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            bus0.rd_sop = 1'b0;
            checks++;
            if ({bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err} !== {m_vld, m_sop, m_eop, m_busy, m_err}) begin
                errors++; $display("FAIL basic_ctl n %0d got %b want %b", n, {bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err}, {m_vld, m_sop, m_eop, m_busy, m_err});
            end
            if (bus0.res_vld === 1'b1) begin
                n_res++;
                if (first < 0) first = n;
                checks++; if (bus0.res_data !== 35'd36) begin errors++; $display("FAIL basic_data n %0d got %0d want 36", n, bus0.res_data); end
                checks++; if (bus0.res_sop !== (n_res == 1)) begin errors++; $display("FAIL basic_sop n %0d got %b want %b", n, bus0.res_sop, n_res == 1); end
                checks++; if (bus0.res_eop !== (n_res == 8)) begin errors++; $display("FAIL basic_eop n %0d got %b want %b", n, bus0.res_eop, n_res == 8); end
            end
        end
        checks++; if (n_res != 8) begin errors++; $display("FAIL basic_count got %0d want 8", n_res); end
        checks++; if (first != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", first); end
    endtask

    // Most negative lanes and weights -> 8 * 2^30 with no sign error.
    task automatic test_extreme();
        int n_res = 0;
        load_weights0(16'h8000, 1'b0);
        for (int i = 0; i < 8; i++) bus0.wt_data = 16'h8000;
        bus0.wt_vld = 1'b0;
        // load_weights0 adds i to the base; rewrite with the exact value
        for (int i = 0; i < 8; i++) begin
            bus0.wt_vld  = 1'b1;
            bus0.wt_data = 16'h8000;
            tick();
        end
        bus0.wt_vld  = 1'b0;
        bus0.pe_data = {8{16'h8000}};
        bus0.rd_sop  = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            bus0.rd_sop = 1'b0;
            checks++;
            if ({bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy} !== {m_vld, m_sop, m_eop, m_busy}) begin
                errors++; $display("FAIL extreme_ctl n %0d got %b want %b", n, {bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy}, {m_vld, m_sop, m_eop, m_busy});
            end
            if (bus0.res_vld === 1'b1) begin
                n_res++;
                checks++; if (bus0.res_data !== 35'h200000000) begin errors++; $display("FAIL extreme_data n %0d got %h want 200000000", n, bus0.res_data); end
            end
        end
        checks++; if (n_res != 8) begin errors++; $display("FAIL extreme_count got %0d want 8", n_res); end
    endtask

    // rd_sop during RUN and in the last DRAIN cycle is dropped; the next
    // IDLE cycle accepts it.
    task automatic test_resop_busy();
        int n_first = 0;
        int n_all   = 0;
        load_weights0(16'd0, 1'b1);
        bus0.rd_sop  = 1'b1;
        bus0.pe_data = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 1; n <= 26; n++) begin
            tick();
            checks++;
            if ({bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err} !== {m_vld, m_sop, m_eop, m_busy, m_err}) begin
                errors++; $display("FAIL resop_ctl n %0d got %b want %b", n, {bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err}, {m_vld, m_sop, m_eop, m_busy, m_err});
            end
            checks++; if (bus0.res_data !== m_data) begin errors++; $display("FAIL resop_data n %0d got %h want %h", n, bus0.res_data, m_data); end
            if (bus0.res_vld === 1'b1) begin
                n_all++;
                if (n <= 11) n_first++;
            end
            if (n == 5) begin
                checks++; if (bus0.err !== 1'b1) begin errors++; $display("FAIL resop_err got %b want 1", bus0.err); end
            end
            bus0.rd_sop  = (n == 4) || (n == 11) || (n == 12);
            bus0.pe_data = {$urandom, $urandom, $urandom, $urandom};
        end
        checks++; if (n_first != WIN_LEN) begin errors++; $display("FAIL resop_count got %0d want %0d", n_first, WIN_LEN); end
        checks++; if (n_all != 2 * WIN_LEN) begin errors++; $display("FAIL resop_total got %0d want %0d", n_all, 2 * WIN_LEN); end
    endtask

    // New weights written during RUN apply only to the following window.
    task automatic test_weight_update();
        load_weights0(16'd0, 1'b1);
        bus0.rd_sop  = 1'b1;
        bus0.pe_data = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 1; n <= 30; n++) begin
            tick();
            checks++;
            if ({bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy} !== {m_vld, m_sop, m_eop, m_busy}) begin
                errors++; $display("FAIL wupd_ctl n %0d got %b want %b", n, {bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy}, {m_vld, m_sop, m_eop, m_busy});
            end
            checks++; if (bus0.res_data !== m_data) begin errors++; $display("FAIL wupd_data n %0d got %h want %h", n, bus0.res_data, m_data); end
            bus0.rd_sop  = (n == 13);
            bus0.wt_vld  = (n >= 2) && (n <= 9);
            bus0.wt_data = 16'($urandom);
            bus0.pe_data = {$urandom, $urandom, $urandom, $urandom};
        end
        bus0.wt_vld = 1'b0;
    endtask

    // One reset cycle in WAIT aborts the window; a fresh rd_sop then works.
    task automatic test_rst_in_wait();
        int n_res = 0;
        load_weights0(16'd0, 1'b1);
        bus0.rd_sop  = 1'b1;
        bus0.pe_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bus0.rd_sop = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err} !== 5'b0) begin errors++; $display("FAIL rstw_ctl got %b want 00000", {bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err}); end
        checks++; if (bus0.res_data !== 35'd0) begin errors++; $display("FAIL rstw_data got %h want 0", bus0.res_data); end
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus0.res_vld !== 1'b0) n_res++;
        end
        checks++; if (n_res != 0) begin errors++; $display("FAIL rstw_pulses got %0d want 0", n_res); end
        load_weights0(16'd0, 1'b1);
        bus0.rd_sop = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            bus0.rd_sop  = 1'b0;
            bus0.pe_data = {$urandom, $urandom, $urandom, $urandom};
            checks++;
            if ({bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err} !== {m_vld, m_sop, m_eop, m_busy, m_err}) begin
                errors++; $display("FAIL rstw_win_ctl n %0d got %b want %b", n, {bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err}, {m_vld, m_sop, m_eop, m_busy, m_err});
            end
            checks++; if (bus0.res_data !== m_data) begin errors++; $display("FAIL rstw_win_data n %0d got %h want %h", n, bus0.res_data, m_data); end
        end
    endtask

    // Free-running random traffic, including pulses while busy.
    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus0.rd_sop  = ($urandom_range(0, 7) == 0);
            bus0.wt_vld  = ($urandom_range(0, 2) == 0);
            bus0.wt_data = 16'($urandom);
            bus0.pe_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            checks++;
            if ({bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err} !== {m_vld, m_sop, m_eop, m_busy, m_err}) begin
                errors++; $display("FAIL rand_ctl n %0d got %b want %b", n, {bus0.res_vld, bus0.res_sop, bus0.res_eop, bus0.busy, bus0.err}, {m_vld, m_sop, m_eop, m_busy, m_err});
            end
            checks++; if (bus0.res_data !== m_data) begin errors++; $display("FAIL rand_data n %0d got %h want %h", n, bus0.res_data, m_data); end
        end
        bus0.rd_sop = 1'b0;
        bus0.wt_vld = 1'b0;
    endtask

    // WIN_LEN=1: rd_sop every 5 cycles, one sop+eop result per window.
    task automatic test_win1_back_to_back();
        int          w1 [8];
        logic [127:0] cap;
        logic [34:0] exp_d;
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            bus1.wt_vld  = 1'b1;
            bus1.wt_data = 16'($urandom);
            w1[i] = int'($signed(bus1.wt_data));
            tick();
        end
        bus1.wt_vld = 1'b0;
        for (int w = 0; w < 6; w++) begin
            bus1.rd_sop  = 1'b1;
            bus1.pe_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            for (int n = 1; n <= 5; n++) begin
                bus1.rd_sop = 1'b0;
                checks++; if (bus1.res_vld !== (n == 4)) begin errors++; $display("FAIL win1_vld w %0d n %0d got %b want %b", w, n, bus1.res_vld, n == 4); end
                checks++; if (bus1.busy !== (n <= 4)) begin errors++; $display("FAIL win1_busy w %0d n %0d got %b want %b", w, n, bus1.busy, n <= 4); end
                if (n == 4) begin
                    exp_d = 35'(dot(cap, w1));
                    checks++; if (bus1.res_data !== exp_d) begin errors++; $display("FAIL win1_data w %0d got %h want %h", w, bus1.res_data, exp_d); end
                    checks++; if ({bus1.res_sop, bus1.res_eop} !== 2'b11) begin errors++; $display("FAIL win1_sopeop w %0d got %b want 11", w, {bus1.res_sop, bus1.res_eop}); end
                end
                bus1.pe_data = {$urandom, $urandom, $urandom, $urandom};
                if (n == 2) cap = bus1.pe_data;
                if (n < 5) tick();
            end
        end
        checks++; if (bus1.err !== 1'b0) begin errors++; $display("FAIL win1_err got %b want 0", bus1.err); end
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        bus0.rd_sop  = 1'b0;
        bus0.pe_data = '0;
        bus0.wt_vld  = 1'b0;
        bus0.wt_data = '0;
        bus1.rd_sop  = 1'b0;
        bus1.pe_data = '0;
        bus1.wt_vld  = 1'b0;
        bus1.wt_data = '0;
        test_reset();
        test_basic();
        test_extreme();
        test_resop_busy();
        test_weight_update();
        test_rst_in_wait();
        test_random();
        test_win1_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pe_dot_row
`default_nettype wire

// File: doc/pe_dot_row.md
PE_DOT_ROW -- requirements
Module: pe_dot_row

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: cycles from rd_sop to the first valid pe_data word; legal range 1..15.
REQ-002 SHALL have parameter WIN_LEN, default 8: pe_data words consumed per window; legal range 1..16.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rd_sop  input  1  window start pulse, shared with the upstream RAM read controllers.
REQ-006 SHALL have port pe_data  input  128  eight signed 16-bit lanes; lane i = bits [16i+15:16i].
REQ-007 SHALL have port wt_vld  input  1  weight write strobe.
REQ-008 SHALL have port wt_data  input  16  signed weight word.
REQ-009 SHALL have port res_vld  output  1  res_data valid.
REQ-010 SHALL have port res_sop  output  1  first result of a window, coincident with res_vld.
REQ-011 SHALL have port res_eop  output  1  last result of a window, coincident with res_vld.
REQ-012 SHALL have port res_data  output  35  signed dot product of one pe_data word with the active weights.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port err  output  1  sticky error flag, cleared only by rst.

Function
REQ-015 SHALL hold two 8x16 weight banks: shadow and active.
REQ-016 Each wt_vld cycle SHALL write wt_data to shadow[wptr], then increment wptr modulo 8.
REQ-017 On rd_sop accepted in IDLE, SHALL copy shadow to active in that cycle and reset wptr to 0.
REQ-018 SHALL implement FSM IDLE -> WAIT -> RUN -> DRAIN -> IDLE.
REQ-019 IDLE->WAIT on rd_sop; WAIT loads its cycle counter with RD_LAT-1 and counts down.
REQ-020 WAIT->RUN when the counter reaches 0. The first sampling cycle is exactly RD_LAT cycles after the rd_sop cycle.
REQ-021 RUN SHALL sample pe_data on WIN_LEN consecutive cycles, then go to DRAIN.
REQ-022 DRAIN SHALL last 2 cycles, then go to IDLE.
REQ-023 Pipeline: sample cycle t registers 8 signed 16x16 products (32 bits each); the adder tree registers the 35-bit sum at t+1; res_vld is high in cycle t+2.
REQ-024 Arithmetic SHALL be full-precision two's complement, with no saturation or truncation; 35 bits cannot overflow.
REQ-025 res_sop SHALL mark the result of the first sample and res_eop the result of the last; with WIN_LEN=1 both are high together.
REQ-026 rd_sop while busy SHALL be ignored (no restart, no weight swap) and SHALL set err.
REQ-027 wt_vld while busy SHALL be accepted into shadow only; active weights stay unchanged for the current window.
REQ-028 wt_vld in the same cycle as an accepted rd_sop SHALL write shadow after the copy; that word applies to the next window.
REQ-029 rd_sop in the last DRAIN cycle SHALL be rejected; it is accepted from the following IDLE cycle onward.
REQ-030 res_data SHALL hold its last value when res_vld is low.

Reset
REQ-031 On rst SHALL clear: FSM to IDLE, wptr=0, counters=0, both weight banks=0, pipeline valid bits=0.
REQ-032 Reset values SHALL be res_vld=0, res_sop=0, res_eop=0, res_data=0, busy=0, err=0.
REQ-033 rst mid-window SHALL abort immediately; no res_vld is produced after the reset cycle.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, LANES=8, DW=16, and RES_W=35.
REQ-035 The adder tree (8 inputs, 32 bits each, 35-bit output, one register stage) SHALL be sub-module pe_add_tree8.

Verification
REQ-036 Load weights 1..8, hold all lanes at 1, pulse rd_sop -> 8 results of 36; res_sop on the first result, res_eop on the last; first res_vld 4 cycles after rd_sop.
REQ-037 Lane i = -32768 for all i, all weights -32768 -> each res_data = 8*2^30 = 0x200000000, no sign error.
REQ-038 rd_sop re-pulsed during RUN -> err=1; result count stays WIN_LEN; timing unchanged.
REQ-039 Write 8 new weights during RUN -> current window uses the old weights; the next window uses the new ones.
REQ-040 Assert rst for 1 cycle in WAIT -> all outputs 0 and zero res_vld pulses; a fresh rd_sop then gives a normal window.
REQ-041 WIN_LEN=1, back-to-back rd_sop every 5 cycles -> each rd_sop accepted; one result per window with res_sop=res_eop=1; err stays 0.
